// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
package fifo_stream_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int CNT_WIDTH_DEF  = 16;
   localparam int SKID_DEPTH     = 2;

   typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream, grouped for the adapter.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = fifo_stream_pkg::DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = fifo_stream_pkg::CNT_WIDTH_DEF
) ();
   logic                  empty;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_en;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;
   logic                  flush;
   logic [CNT_WIDTH-1:0]  beat_cnt;

   modport master (
      input  empty, rd_data, m_ready, flush,
      output rd_en, m_valid, m_data, beat_cnt
   );

   modport slave (
      output empty, rd_data, m_ready, flush,
      input  rd_en, m_valid, m_data, beat_cnt
   );
endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry circular register buffer with push/pop/clear; head is always buf[rptr].
module skid_buf2
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output occ_t                  occ_o,
   output logic [DATA_WIDTH-1:0] head_o
);
   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  wptr_q, wptr_d;
   logic                  rptr_q, rptr_d;
   occ_t                  occ_q, occ_d;

   always_comb begin
      occ_d  = occ_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clear_i) begin
         occ_d  = '0;
         wptr_d = 1'b0;
         rptr_d = 1'b0;
      end else begin
         if (push_i) wptr_d = ~wptr_q;
         if (pop_i)  rptr_d = ~rptr_q;
         case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         occ_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push_i && !clear_i) mem_q[wptr_q] <= push_data_i;
      end
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rptr_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of async_fifo: pops words on credit and presents them as a stream.
module fifo_rd_stream
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic              rd_clk,
   input  logic              rd_rst_n,
   fifo_rd_stream_if.master  bus
);
   occ_t                  occ;
   logic [DATA_WIDTH-1:0] head;
   logic                  inflight_q;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic                  m_valid, pop, capture, rd_en;
   logic [2:0]            credit_used;

   assign m_valid     = (occ != 2'd0);
   assign pop         = m_valid && bus.m_ready;
   assign capture     = inflight_q && !bus.flush;
   assign credit_used = {1'b0, occ} + {2'b00, inflight_q};

   // A pop this cycle frees a slot, so the request may go out in the same cycle.
   assign rd_en = rd_rst_n && !bus.flush && !bus.empty &&
                  (credit_used < (3'd2 + {2'b00, pop}));

   assign beat_cnt_d = pop ? beat_cnt_q + CNT_WIDTH'(1) : beat_cnt_q;

   skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk         (rd_clk),
      .rst_n       (rd_rst_n),
      .clear_i     (bus.flush),
      .push_i      (capture),
      .push_data_i (bus.rd_data),
      .pop_i       (pop),
      .occ_o       (occ),
      .head_o      (head)
   );

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         inflight_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         inflight_q <= rd_en;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.rd_en    = rd_en;
   assign bus.m_valid  = m_valid;
   assign bus.m_data   = head;
   assign bus.beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scenario bench for fifo_rd_stream with a FIFO model and a scoreboard of expected beats.
module tb_fifo_rd_stream;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bif ();
   fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bif4 ();

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .rd_clk   (clk),
      .rd_rst_n (rst_n),
      .bus      (bif.master)
   );

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
      .rd_clk   (clk),
      .rd_rst_n (rst_n),
      .bus      (bif4.master)
   );

   assign bif4.empty   = bif.empty;
   assign bif4.rd_data = bif.rd_data;
   assign bif4.m_ready = bif.m_ready;
   assign bif4.flush   = bif.flush;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fifo_q [$];
   logic [DW-1:0] exp_q  [$];

   bit rdy_v, flush_v, gap_v;

   logic          s_rd_en, s_valid;
   logic [DW-1:0] s_data;
   logic [15:0]   s_cnt;
   logic [3:0]    s_cnt4;
   bit            s_pop;

   int outst      = 0;
   int viol_empty = 0;
   int viol_occ   = 0;

   // One read-clock cycle: apply inputs, sample after settling, then model the FIFO pop.
   task automatic tick();
      bif.m_ready = rdy_v;
      bif.flush   = flush_v;
      bif.empty   = (fifo_q.size() == 0) || gap_v;
      #1;
      s_rd_en = bif.rd_en;
      s_valid = bif.m_valid;
      s_data  = bif.m_data;
      s_cnt   = bif.beat_cnt;
      s_cnt4  = bif4.beat_cnt;
      s_pop   = (bif.m_valid === 1'b1) && rdy_v;
      if ((s_rd_en === 1'b1) && bif.empty) viol_empty++;
      if (!rst_n) outst = 0;
      else begin
         outst = outst + int'(s_rd_en === 1'b1) - int'(s_pop);
         if (flush_v) outst = 0;
      end
      if (outst > 2) viol_occ++;
      @(posedge clk);
      #1;
      if ((s_rd_en === 1'b1) && fifo_q.size() > 0) bif.rd_data = fifo_q.pop_front();
      else bif.rd_data = 8'hEE;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy_v = 1; flush_v = 0; gap_v = 0;
      fifo_q.push_back(8'hAA);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (s_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en cyc=%0d got=%b exp=0", i, s_rd_en); end
         total++;
         if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid cyc=%0d got=%b exp=0", i, s_valid); end
         total++;
         if (s_data !== 8'h00) begin bad++; $display("FAIL reset_m_data cyc=%0d got=%h exp=00", i, s_data); end
         total++;
         if (s_cnt !== 16'd0) begin bad++; $display("FAIL reset_beat_cnt cyc=%0d got=%0d exp=0", i, s_cnt); end
      end
      fifo_q.delete();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_streaming();
      logic [DW-1:0] e;
      for (int i = 1; i <= 16; i++) begin
         fifo_q.push_back(8'(i));
         exp_q.push_back(8'(i));
      end
      rdy_v = 1;
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if ((s_rd_en === 1'b1) != (c < 16)) begin
            bad++; $display("FAIL stream_rd_en cyc=%0d got=%b exp=%0d", c, s_rd_en, (c < 16));
         end
         total++;
         if ((s_valid === 1'b1) != (c >= 2 && c < 18)) begin
            bad++; $display("FAIL stream_m_valid cyc=%0d got=%b exp=%0d", c, s_valid, (c >= 2 && c < 18));
         end
         if (s_pop) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, s_data, e); end
            end
         end
      end
      total++;
      if (s_cnt !== 16'd16) begin bad++; $display("FAIL stream_beat_cnt got=%0d exp=16", s_cnt); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] e;
      int n_rd = 0;
      int got  = 0;
      for (int i = 1; i <= 8; i++) begin
         fifo_q.push_back(8'(i));
         exp_q.push_back(8'(i));
      end
      rdy_v = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (s_rd_en === 1'b1) n_rd++;
         if (c >= 2) begin
            total++;
            if (s_valid !== 1'b1 || s_data !== 8'h01) begin
               bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/01", c, s_valid, s_data);
            end
         end
      end
      total++;
      if (n_rd != 2) begin bad++; $display("FAIL bp_rd_en_pulses got=%0d exp=2", n_rd); end
      rdy_v = 1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c < 8) begin
            total++;
            if (s_valid !== 1'b1) begin bad++; $display("FAIL bp_gap cyc=%0d got=%b exp=1", c, s_valid); end
         end
         if (s_pop) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, s_data, e); end
            end
         end
      end
      total++;
      if (got != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got); end
      total++;
      if (s_cnt !== 16'd24) begin bad++; $display("FAIL bp_beat_cnt got=%0d exp=24", s_cnt); end
   endtask

   task automatic test_flush();
      logic [DW-1:0] e;
      logic [15:0]   cnt_f;
      int got = 0;
      // Words A1/A2 are sitting in the adapter when flush hits and must never appear.
      fifo_q = '{8'h01, 8'h02, 8'h03, 8'hA1, 8'hA2, 8'h04, 8'h05};
      exp_q  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      cnt_f  = '0;
      for (int c = 0; c < 16; c++) begin
         rdy_v   = (c != 5);
         flush_v = (c == 5);
         tick();
         if (c == 5) begin
            cnt_f = s_cnt;
            total++;
            if (s_rd_en !== 1'b0) begin bad++; $display("FAIL flush_rd_en got=%b exp=0", s_rd_en); end
         end
         if (c == 6) begin
            total++;
            if (s_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got=%b exp=0", s_valid); end
            total++;
            if (s_cnt !== cnt_f) begin bad++; $display("FAIL flush_beat_cnt got=%0d exp=%0d", s_cnt, cnt_f); end
         end
         if (s_pop) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL flush_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL flush_data cyc=%0d got=%h exp=%h", c, s_data, e); end
            end
         end
      end
      flush_v = 0;
      total++;
      if (got != 5) begin bad++; $display("FAIL flush_count got=%0d exp=5", got); end

      // Flush in a cycle that also pops: the pop counts, the in-flight word is dropped.
      fifo_q = '{8'hB1, 8'hB2, 8'h06};
      exp_q  = '{8'hB1, 8'h06};
      got = 0;
      rdy_v = 1;
      for (int c = 0; c < 10; c++) begin
         flush_v = (c == 2);
         tick();
         if (c == 2) begin
            cnt_f = s_cnt;
            total++;
            if (s_rd_en !== 1'b0) begin bad++; $display("FAIL flushpop_rd_en got=%b exp=0", s_rd_en); end
         end
         if (c == 3) begin
            total++;
            if (s_valid !== 1'b0) begin bad++; $display("FAIL flushpop_m_valid got=%b exp=0", s_valid); end
            total++;
            if (s_cnt !== cnt_f + 16'd1) begin bad++; $display("FAIL flushpop_beat_cnt got=%0d exp=%0d", s_cnt, cnt_f + 16'd1); end
         end
         if (s_pop) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL flushpop_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL flushpop_data cyc=%0d got=%h exp=%h", c, s_data, e); end
            end
         end
      end
      flush_v = 0;
      total++;
      if (got != 2) begin bad++; $display("FAIL flushpop_count got=%0d exp=2", got); end
   endtask

   task automatic test_wrap_empty();
      logic [DW-1:0] e;
      int n_rd = 0;
      int got  = 0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         fifo_q.push_back(8'(i + 8'h40));
         exp_q.push_back(8'(i + 8'h40));
      end
      rdy_v = 1;
      for (int c = 0; c < 25; c++) begin
         gap_v = (c == 5);
         tick();
         if (s_rd_en === 1'b1) n_rd++;
         if (c == 5) begin
            total++;
            if (s_rd_en !== 1'b0) begin bad++; $display("FAIL gap_rd_en got=%b exp=0", s_rd_en); end
         end
         if (s_pop) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL wrap_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", c, s_data, e); end
            end
         end
      end
      gap_v = 0;
      total++;
      if (got != 17) begin bad++; $display("FAIL wrap_count got=%0d exp=17", got); end
      total++;
      if (n_rd != 17) begin bad++; $display("FAIL wrap_rd_en_pulses got=%0d exp=17", n_rd); end
      total++;
      if (s_cnt4 !== 4'd1) begin bad++; $display("FAIL wrap_beat_cnt4 got=%0d exp=1", s_cnt4); end
      total++;
      if (s_cnt !== 16'd17) begin bad++; $display("FAIL wrap_beat_cnt16 got=%0d exp=17", s_cnt); end
   endtask

   task automatic test_random();
      logic [DW-1:0] e, w;
      int got = 0;
      for (int i = 0; i < 32; i++) begin
         w = 8'($urandom_range(0, 255));
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      for (int c = 0; c < 600 && got < 32; c++) begin
         gap_v = ($urandom_range(0, 3) == 0);
         rdy_v = ($urandom_range(0, 1) == 1);
         tick();
         if (s_pop) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra_beat got=%h exp=none", s_data); end
            else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin bad++; $display("FAIL rand_data beat=%0d got=%h exp=%h", got, s_data, e); end
            end
         end
      end
      gap_v = 0;
      rdy_v = 1;
      total++;
      if (got != 32) begin bad++; $display("FAIL rand_count got=%0d exp=32", got); end
      total++;
      if (viol_empty != 0) begin bad++; $display("FAIL rd_en_while_empty got=%0d exp=0", viol_empty); end
      total++;
      if (viol_occ != 0) begin bad++; $display("FAIL occ_plus_inflight got=%0d exp=0", viol_occ); end
   endtask

   initial begin
      bif.empty   = 1'b1;
      bif.rd_data = 8'hEE;
      bif.m_ready = 1'b0;
      bif.flush   = 1'b0;
      rst_n       = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wrap_empty();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
